dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/riscv_mem_pkg.sv | 32 +++
 rtl/dmem_bank.sv | 34 +++
 rtl/dmem_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - func3 encodings, FSM states and legality helpers for the data memory controller
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        RESP  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_e;

    // Loads accept both signed and unsigned byte/half encodings plus LW.
    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Stores have no signedness, so only the three size encodings are legal.
    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - four byte-lane synchronous RAM with per-lane write enables and registered read
module dmem_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-3:0] word_addr_i,
    input  logic [3:0]        lane_we_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    logic [7:0]  lane_mem_q [4][DEPTH];
    logic [31:0] rdata_q;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        // Each byte lane commits independently so partial stores leave other lanes intact.
        always_ff @(posedge clk) begin
            if (lane_we_i[g]) begin
                lane_mem_q[g][word_addr_i] <= wdata_i[8*g +: 8];
            end
        end
    end

    // Registered read of the whole word; lane 0 is the least significant byte.
    always_ff @(posedge clk) begin
        rdata_q <= {lane_mem_q[3][word_addr_i], lane_mem_q[2][word_addr_i],
                    lane_mem_q[1][word_addr_i], lane_mem_q[0][word_addr_i]};
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data memory controller: request checks, load/store FSM, lane steering and load extension
module dmem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_mem_we,
    input  logic        d_mem_re,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        func3_q, func3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        req;
    logic        fault;
    logic        f3_bad;
    logic        align_bad;
    logic        range_bad;
    logic [3:0]  lane_mask;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [31:0] bank_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    assign req = d_mem_we | d_mem_re;

    // Classify the incoming request; only meaningful while IDLE.
    always_comb begin
        f3_bad    = 1'b0;
        align_bad = 1'b0;
        range_bad = (addr >> ADDR_W) != 32'd0;
        if (d_mem_we && d_mem_re) begin
            f3_bad = 1'b1;
        end else if (d_mem_we) begin
            f3_bad = !store_f3_ok(func3);
        end else begin
            f3_bad = !load_f3_ok(func3);
        end
        case (func3[1:0])
            2'b01:   align_bad = addr[0];
            2'b10:   align_bad = addr[1:0] != 2'b00;
            default: align_bad = 1'b0;
        endcase
        fault = f3_bad | align_bad | range_bad;
    end

    // State and latched request fields; memory array is not reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            func3_q <= 3'b000;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state, request capture and handshake outputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        wdata_d = wdata_q;
        ready   = 1'b0;
        err     = 1'b0;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    addr_d  = addr[ADDR_W-1:0];
                    func3_d = func3;
                    wdata_d = wdata;
                    if (fault) begin
                        state_d = ERR;
                    end else if (d_mem_we) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = RESP;
            end
            RESP: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            WRITE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                ready   = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Steer store data onto byte lanes and pick which lanes to write.
    always_comb begin
        lane_mask  = 4'b0000;
        lane_wdata = wdata_q;
        case (func3_q[1:0])
            2'b00: begin
                lane_wdata = {4{wdata_q[7:0]}};
                lane_mask  = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                lane_wdata = {2{wdata_q[15:0]}};
                lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = wdata_q;
                lane_mask  = 4'b1111;
            end
        endcase
    end

    // Reset in the WRITE cycle must suppress the commit on that same edge.
    assign lane_we = (state_q == WRITE && rst_n) ? lane_mask : 4'b0000;

    dmem_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk         (clk),
        .word_addr_i (addr_q[ADDR_W-1:2]),
        .lane_we_i   (lane_we),
        .wdata_i     (lane_wdata),
        .rdata_o     (bank_rdata)
    );

    // Select the addressed byte/half from the read word and extend it.
    always_comb begin
        ld_byte = bank_rdata[7:0];
        case (addr_q[1:0])
            2'b00:   ld_byte = bank_rdata[7:0];
            2'b01:   ld_byte = bank_rdata[15:8];
            2'b10:   ld_byte = bank_rdata[23:16];
            default: ld_byte = bank_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bank_rdata[31:16] : bank_rdata[15:0];
        case (func3_q)
            F3_LB:   load_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   load_ext = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  load_ext = {24'd0, ld_byte};
            F3_LHU:  load_ext = {16'd0, ld_half};
            default: load_ext = bank_rdata;
        endcase
    end

    // Fresh load data is visible during RESP and held afterwards until the next RESP.
    always_comb begin
        rdata_d = (state_q == RESP) ? load_ext : rdata_q;
    end

    assign rdata = rdata_d;

endmodule
